// File: rtl/xcvr_ref_clk_gen.sv
// Fabric-side transceiver reference clock source: 50% duty divided clock as a P/N pair.
// Latency: EN_REQ sampled at edge t -> EN_ACK at t+2, first P rise at t+2+hp.
// No backpressure; start/stop via EN_REQ/EN_ACK handshake, divide changes at period boundaries.
module xcvr_ref_clk_gen #(
    parameter int DIV_W        = 8,
    parameter int DEFAULT_HALF = 4,
    parameter int CYC_W        = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN_REQ,
    output logic             EN_ACK,
    input  logic [DIV_W-1:0] DIV_HALF,
    input  logic             DIV_LOAD,
    output logic             DIV_ERR,
    output logic             REF_CLK_OUT_P,
    output logic             REF_CLK_OUT_N,
    output logic             PERIOD_STB,
    output logic [CYC_W-1:0] CYCLE_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_RUN       = 2'd2,
        ST_STOP_WAIT = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] HP_RST  = DIV_W'(DEFAULT_HALF);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] hp_q, hp_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             p_q, p_d;
    logic             n_q, n_d;
    logic             stb_q, stb_d;
    logic             err_q, err_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;

    logic active;
    logic toggle;
    logic rise;
    logic fall;
    logic load_ok;
    logic apply;

    // Toggle engine runs in RUN and STOP_WAIT; a falling toggle closes a full period.
    assign active  = (state_q == ST_RUN) || (state_q == ST_STOP_WAIT);
    assign toggle  = active && (cnt_q == (hp_q - DIV_ONE));
    assign rise    = toggle && !p_q;
    assign fall    = toggle && p_q;
    assign load_ok = DIV_LOAD && (DIV_HALF != '0);
    // Pending value only lands on a full-period boundary or when starting, so no runt phase.
    assign apply   = pend_vld_q && (fall || (state_q == ST_START));

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; STOP_WAIT leaves only on a falling toggle so the last high phase is whole.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (EN_REQ) state_d = ST_START;
            ST_START:     state_d = ST_RUN;
            ST_RUN:       if (!EN_REQ) state_d = ST_STOP_WAIT;
            ST_STOP_WAIT: begin
                if (EN_REQ) begin
                    state_d = ST_RUN;
                end else if (fall) begin
                    state_d = ST_IDLE;
                end
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output decode: acknowledge only while fully running.
    always_comb begin
        EN_ACK        = (state_q == ST_RUN);
        DIV_ERR       = err_q;
        REF_CLK_OUT_P = p_q;
        REF_CLK_OUT_N = n_q;
        PERIOD_STB    = stb_q;
        CYCLE_CNT     = cyc_q;
    end

    // Datapath next-state: divider counter, output phase, pending divide, period counter.
    always_comb begin
        cnt_d      = cnt_q;
        p_d        = p_q;
        cyc_d      = cyc_q;
        hp_d       = apply ? pend_q : hp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        stb_d      = rise;
        err_d      = DIV_LOAD && (DIV_HALF == '0);

        // A load coinciding with a boundary is kept pending for the next boundary.
        if (load_ok) begin
            pend_d     = DIV_HALF;
            pend_vld_d = 1'b1;
        end else if (apply) begin
            pend_vld_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                p_d   = 1'b0;
            end
            ST_START: begin
                cnt_d = '0;
                p_d   = 1'b0;
                cyc_d = '0;
            end
            default: begin
                if (toggle) begin
                    cnt_d = '0;
                    p_d   = ~p_q;
                    if (rise) begin
                        cyc_d = cyc_q + CYC_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_ONE;
                end
            end
        endcase
        n_d = ~p_d;
    end

    // Datapath registers; reset truncates any phase in progress.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hp_q       <= HP_RST;
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            p_q        <= 1'b0;
            n_q        <= 1'b1;
            stb_q      <= 1'b0;
            err_q      <= 1'b0;
            cyc_q      <= '0;
        end else begin
            hp_q       <= hp_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            p_q        <= p_d;
            n_q        <= n_d;
            stb_q      <= stb_d;
            err_q      <= err_d;
            cyc_q      <= cyc_d;
        end
    end

endmodule

// File: tb/tb_xcvr_ref_clk_gen.sv
// Bench for xcvr_ref_clk_gen: directed start/stop/divide scenarios with an event scoreboard.
// Expected events (rise, fall, ack edges, divide error) are queued with absolute cycle numbers.
// A negedge monitor pops and compares every observed event; static state checked directly.
module tb_xcvr_ref_clk_gen;

    localparam int DIV_W = 8;
    localparam int CYC_W = 4;

    localparam int EV_RISE   = 0;
    localparam int EV_FALL   = 1;
    localparam int EV_ACK_UP = 2;
    localparam int EV_ACK_DN = 3;
    localparam int EV_ERR    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en_req;
    logic             div_load;
    logic [DIV_W-1:0] div_half;
    logic             en_ack;
    logic             div_err;
    logic             p_out;
    logic             n_out;
    logic             pstb;
    logic [CYC_W-1:0] cyc_cnt;

    always #5 clk = ~clk;

    xcvr_ref_clk_gen #(
        .DIV_W       (DIV_W),
        .DEFAULT_HALF(4),
        .CYC_W       (CYC_W)
    ) dut (
        .CLK          (clk),
        .RESET        (rst),
        .EN_REQ       (en_req),
        .EN_ACK       (en_ack),
        .DIV_HALF     (div_half),
        .DIV_LOAD     (div_load),
        .DIV_ERR      (div_err),
        .REF_CLK_OUT_P(p_out),
        .REF_CLK_OUT_N(n_out),
        .PERIOD_STB   (pstb),
        .CYCLE_CNT    (cyc_cnt)
    );

    typedef struct {
        int kind;
        int cyc;
        int data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    logic p_prev   = 1'b0;
    logic ack_prev = 1'b0;
    int   c0, c1, r;

    always @(posedge clk) cyc = cyc + 1;

    function automatic string kname(input int k);
        case (k)
            EV_RISE:   return "rise";
            EV_FALL:   return "fall";
            EV_ACK_UP: return "ack_up";
            EV_ACK_DN: return "ack_dn";
            EV_ERR:    return "div_err";
            default:   return "unknown";
        endcase
    endfunction

    function automatic void push(input int k, input int c, input int d);
        exp_t e;
        e.kind = k;
        e.cyc  = c;
        e.data = d;
        sb.push_back(e);
    endfunction

    task automatic observe(input int k, input int d);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got %s at cycle %0d data=%0d, required no event",
                     kname(k), cyc, d);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.cyc != cyc || e.data != d) begin
                failures++;
                $display("FAIL event: got %s cycle=%0d data=%0d, required %s cycle=%0d data=%0d",
                         kname(k), cyc, d, kname(e.kind), e.cyc, e.data);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    // Event monitor, sampling away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (pstb)               observe(EV_RISE, int'(cyc_cnt));
            if (p_prev && !p_out)   observe(EV_FALL, 0);
            if (!ack_prev && en_ack) observe(EV_ACK_UP, 0);
            if (ack_prev && !en_ack) observe(EV_ACK_DN, 0);
            if (div_err)            observe(EV_ERR, 0);
            checks++;
            if (n_out !== ~p_out) begin
                failures++;
                $display("FAIL n_is_not_p: got N=%b with P=%b, required N=%b (cycle %0d)",
                         n_out, p_out, ~p_out, cyc);
            end
        end
        p_prev   = p_out;
        ack_prev = en_ack;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        en_req   = 1'b0;
        div_load = 1'b0;
        div_half = '0;
        tick(3);

        // Reset state.
        chk("rst_p",     32'(p_out),   32'd0);
        chk("rst_n",     32'(n_out),   32'd1);
        chk("rst_ack",   32'(en_ack),  32'd0);
        chk("rst_stb",   32'(pstb),    32'd0);
        chk("rst_err",   32'(div_err), 32'd0);
        chk("rst_cycle", 32'(cyc_cnt), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Start with default half-period 4: period 8, high 4.
        en_req = 1'b1;
        c0 = cyc + 2;
        push(EV_ACK_UP, c0, 0);
        push(EV_RISE, c0 + 4, 1);
        push(EV_FALL, c0 + 8, 0);
        push(EV_RISE, c0 + 12, 2);
        push(EV_FALL, c0 + 16, 0);
        wait_until(c0 + 16);

        // Zero divide load: error pulse, period unchanged.
        div_load = 1'b1;
        div_half = 8'd0;
        push(EV_ERR, c0 + 17, 0);
        tick(1);
        div_load = 1'b0;
        push(EV_RISE, c0 + 20, 3);
        push(EV_FALL, c0 + 24, 0);
        push(EV_RISE, c0 + 28, 4);
        push(EV_FALL, c0 + 32, 0);
        wait_until(c0 + 32);

        // Load half=2 mid high phase: current period completes, then period 4.
        push(EV_RISE, c0 + 36, 5);
        wait_until(c0 + 37);
        div_load = 1'b1;
        div_half = 8'd2;
        tick(1);
        div_load = 1'b0;
        push(EV_FALL, c0 + 40, 0);
        push(EV_RISE, c0 + 42, 6);
        push(EV_FALL, c0 + 44, 0);
        push(EV_RISE, c0 + 46, 7);
        push(EV_FALL, c0 + 48, 0);
        wait_until(c0 + 48);

        // Back to half=4, then stop while P=1 at cnt=1.
        div_load = 1'b1;
        div_half = 8'd4;
        tick(1);
        div_load = 1'b0;
        push(EV_RISE, c0 + 50, 8);
        push(EV_FALL, c0 + 52, 0);
        push(EV_RISE, c0 + 56, 9);
        wait_until(c0 + 57);
        en_req = 1'b0;
        push(EV_ACK_DN, c0 + 58, 0);
        push(EV_FALL, c0 + 60, 0);
        wait_until(c0 + 80);
        chk("idle_p",     32'(p_out),   32'd0);
        chk("idle_ack",   32'(en_ack),  32'd0);
        chk("idle_cycle", 32'(cyc_cnt), 32'd9);

        // Restart, then drop and re-raise EN_REQ inside STOP_WAIT.
        en_req = 1'b1;
        c1 = cyc + 2;
        push(EV_ACK_UP, c1, 0);
        push(EV_RISE, c1 + 4, 1);
        push(EV_FALL, c1 + 8, 0);
        push(EV_RISE, c1 + 12, 2);
        wait_until(c1 + 13);
        en_req = 1'b0;
        push(EV_ACK_DN, c1 + 14, 0);
        tick(1);
        en_req = 1'b1;
        push(EV_ACK_UP, c1 + 15, 0);
        push(EV_FALL, c1 + 16, 0);
        push(EV_RISE, c1 + 20, 3);
        push(EV_FALL, c1 + 24, 0);
        wait_until(c1 + 24);

        // Half-period 1 and CYCLE_CNT wrap at 4 bits.
        div_load = 1'b1;
        div_half = 8'd1;
        tick(1);
        div_load = 1'b0;
        push(EV_RISE, c1 + 28, 4);
        push(EV_FALL, c1 + 32, 0);
        for (int j = 0; j <= 12; j++) begin
            push(EV_RISE, c1 + 33 + 2 * j, (5 + j) % 16);
            if (j < 12) push(EV_FALL, c1 + 34 + 2 * j, 0);
        end
        wait_until(c1 + 57);
        chk("wrap_cycle", 32'(cyc_cnt), 32'd1);
        chk("wrap_p",     32'(p_out),   32'd1);

        // Reset during the high phase.
        rst    = 1'b1;
        en_req = 1'b0;
        tick(1);
        mon_en = 1'b0;
        chk("midrst_p",     32'(p_out),   32'd0);
        chk("midrst_n",     32'(n_out),   32'd1);
        chk("midrst_cycle", 32'(cyc_cnt), 32'd0);
        chk("midrst_ack",   32'(en_ack),  32'd0);
        chk("midrst_stb",   32'(pstb),    32'd0);
        rst = 1'b0;
        tick(1);
        mon_en = 1'b1;

        // Load half=3 in IDLE, applied at START; stop entered with P=0 waits a full high phase.
        div_load = 1'b1;
        div_half = 8'd3;
        tick(1);
        div_load = 1'b0;
        tick(2);
        en_req = 1'b1;
        r = cyc;
        push(EV_ACK_UP, r + 2, 0);
        push(EV_RISE, r + 5, 1);
        push(EV_FALL, r + 8, 0);
        wait_until(r + 8);
        en_req = 1'b0;
        push(EV_ACK_DN, r + 9, 0);
        push(EV_RISE, r + 11, 2);
        push(EV_FALL, r + 14, 0);
        wait_until(r + 30);
        chk("end_p",     32'(p_out),   32'd0);
        chk("end_ack",   32'(en_ack),  32'd0);
        chk("end_cycle", 32'(cyc_cnt), 32'd2);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_events: got %0d expected events never seen, required 0",
                     sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
